// File: rtl/lcd_spi_burst_tx.sv
// SPI transmit engine for the LCD link: streams 8/16-bit words MSB-first,
// holding CS low across a burst with programmable SCLK rate, idle level and CS timing.
module lcd_spi_burst_tx #(
   parameter int CLK_DIV  = 2,
   parameter int CPOL     = 0,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        in_dc,
   input  logic        in_len16,
   input  logic        in_last,
   output logic        lcd_spi_sclk,
   output logic        lcd_spi_mosi,
   output logic        lcd_spi_cs,
   output logic        lcd_dc,
   output logic        busy,
   output logic        done
);

   localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PMAX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int PMAX  = (PMAX0 > CS_IDLE) ? PMAX0 : CS_IDLE;
   localparam int PW    = (PMAX > 1) ? $clog2(PMAX) : 1;
   localparam logic SCLK_IDLE = (CPOL != 0);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_WAIT, S_HOLD, S_CSIDLE} state_t;

   state_t          state;
   logic [DW-1:0]   div_cnt;
   logic [4:0]      bit_cnt;
   logic [PW-1:0]   ph_cnt;
   logic            high_half;
   logic            last_q;
   logic [15:0]     sreg;
   logic [15:0]     word_al;
   logic            accept;

   // 8-bit words are left-aligned so the shifter always emits bit 15 first
   assign word_al  = in_len16 ? in_data : {in_data[7:0], 8'h00};
   assign in_ready = !rst && (state == S_IDLE || state == S_WAIT);
   assign busy     = !rst && (state != S_IDLE);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         lcd_spi_sclk <= SCLK_IDLE;
         lcd_spi_mosi <= 1'b0;
         lcd_spi_cs   <= 1'b1;
         lcd_dc       <= 1'b0;
         done         <= 1'b0;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         ph_cnt       <= '0;
         high_half    <= 1'b0;
         last_q       <= 1'b0;
         sreg         <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               lcd_spi_cs   <= 1'b1;
               lcd_spi_sclk <= SCLK_IDLE;
               if (accept) begin
                  state      <= S_SETUP;
                  lcd_spi_cs <= 1'b0;
                  lcd_dc     <= in_dc;
                  sreg       <= word_al;
                  bit_cnt    <= in_len16 ? 5'd15 : 5'd7;
                  last_q     <= in_last;
                  ph_cnt     <= PW'(CS_SETUP - 1);
               end
            end
            S_SETUP: begin
               if (ph_cnt == '0) begin
                  state        <= S_SHIFT;
                  lcd_spi_sclk <= 1'b0;
                  lcd_spi_mosi <= sreg[15];
                  sreg         <= {sreg[14:0], 1'b0};
                  div_cnt      <= DW'(CLK_DIV - 1);
                  high_half    <= 1'b0;
               end else begin
                  ph_cnt <= ph_cnt - 1'b1;
               end
            end
            S_SHIFT: begin
               if (div_cnt != '0) begin
                  div_cnt <= div_cnt - 1'b1;
               end else if (!high_half) begin
                  lcd_spi_sclk <= 1'b1;
                  high_half    <= 1'b1;
                  div_cnt      <= DW'(CLK_DIV - 1);
               end else if (bit_cnt != '0) begin
                  bit_cnt      <= bit_cnt - 1'b1;
                  lcd_spi_sclk <= 1'b0;
                  high_half    <= 1'b0;
                  lcd_spi_mosi <= sreg[15];
                  sreg         <= {sreg[14:0], 1'b0};
                  div_cnt      <= DW'(CLK_DIV - 1);
               end else begin
                  lcd_spi_sclk <= SCLK_IDLE;
                  high_half    <= 1'b0;
                  if (last_q) begin
                     state  <= S_HOLD;
                     ph_cnt <= PW'(CS_HOLD - 1);
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // next word of the burst starts shifting at once, no CS setup
               if (accept) begin
                  state        <= S_SHIFT;
                  lcd_dc       <= in_dc;
                  bit_cnt      <= in_len16 ? 5'd15 : 5'd7;
                  last_q       <= in_last;
                  lcd_spi_sclk <= 1'b0;
                  lcd_spi_mosi <= word_al[15];
                  sreg         <= {word_al[14:0], 1'b0};
                  div_cnt      <= DW'(CLK_DIV - 1);
                  high_half    <= 1'b0;
               end
            end
            S_HOLD: begin
               if (ph_cnt == '0) begin
                  state      <= S_CSIDLE;
                  lcd_spi_cs <= 1'b1;
                  done       <= 1'b1;
                  ph_cnt     <= PW'(CS_IDLE - 1);
               end else begin
                  ph_cnt <= ph_cnt - 1'b1;
               end
            end
            S_CSIDLE: begin
               if (ph_cnt == '0) state <= S_IDLE;
               else              ph_cnt <= ph_cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
